// File: rtl/roulette_pkg.sv
// roulette_pkg: shared types and helpers for the roulette engine.
//   state_e    : engine FSM states
//   MODE_*     : bet mode encodings on the 2-bit mode input
//   sat_add    : unsigned addition clamped to a caller-supplied maximum
package roulette_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSpin,
      StSettle,
      StResult,
      StBust
   } state_e;

   localparam logic [1:0] MODE_EXACT = 2'b00;
   localparam logic [1:0] MODE_EVEN  = 2'b01;
   localparam logic [1:0] MODE_ODD   = 2'b10;
   localparam logic [1:0] MODE_HIGH  = 2'b11;

   // 33-bit intermediate so the clamp also catches a 32-bit carry-out.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] max);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, max}) ? max : sum[31:0];
   endfunction

endpackage

// File: rtl/roulette_payout.sv
// roulette_payout: combinational bet settlement.
//   mode         : bet mode (MODE_*)
//   guess        : guessed slot, EXACT mode only
//   landed       : slot the wheel stopped on
//   bet          : stake
//   balance      : balance before settlement
//   streak       : consecutive-win count before settlement
//   win          : the bet wins
//   next_balance : balance after settlement (saturating on gains)
// Optional feature macro: ROULETTE_STREAK_EN (streak bonus of +1 on every
// win that brings the streak to a multiple of 3).
module roulette_payout import roulette_pkg::*; #(
   parameter int unsigned NUM_SLOTS  = 32,
   parameter int unsigned SLOT_W     = $clog2(NUM_SLOTS),
   parameter int unsigned BAL_W      = 8,
   parameter int unsigned BET_W      = 4,
   parameter int unsigned EXACT_MULT = 2
) (
   input  logic [1:0]        mode,
   input  logic [SLOT_W-1:0] guess,
   input  logic [SLOT_W-1:0] landed,
   input  logic [BET_W-1:0]  bet,
   input  logic [BAL_W-1:0]  balance,
   input  logic [3:0]        streak,
   output logic              win,
   output logic [BAL_W-1:0]  next_balance
);

   localparam logic [31:0] BAL_MAX = (BAL_W >= 32) ? 32'hffff_ffff : ((32'd1 << BAL_W) - 32'd1);
   localparam logic [31:0] HALF    = NUM_SLOTS / 2;

   logic        bonus;
   logic [31:0] gain;

   // Slot 0 falls out naturally: it is even but excluded, not odd, and below HALF.
   always_comb begin
      win = 1'b0;
      unique case (mode)
         MODE_EXACT: win = (landed == guess);
         MODE_EVEN:  win = !landed[0] && (landed != '0);
         MODE_ODD:   win = landed[0];
         MODE_HIGH:  win = (32'(landed) >= HALF);
         default:    win = 1'b0;
      endcase
   end

`ifdef ROULETTE_STREAK_EN
   logic [3:0] streak_inc;
   assign streak_inc = (streak == 4'd15) ? 4'd15 : streak + 4'd1;
   assign bonus      = win && ((streak_inc % 4'd3) == 4'd0);
`else
   logic unused_streak;
   assign unused_streak = ^streak;
   assign bonus         = 1'b0;
`endif

   assign gain = ((mode == MODE_EXACT) ? 32'(bet) * EXACT_MULT : 32'(bet)) + 32'(bonus);

   // Losses cannot underflow: a start with bet > balance is never accepted.
   assign next_balance = win ? BAL_W'(sat_add(32'(balance), gain, BAL_MAX))
                             : BAL_W'(32'(balance) - 32'(bet));

endmodule

// File: rtl/roulette_engine.sv
// roulette_engine: spin/settle FSM with a saturating player balance.
//   Clock, reset   : rising-edge clock, synchronous active-high reset
//   start          : spin request (level-sampled in IDLE/RESULT)
//   mode, playerGuess, bet : bet description, latched on a legal start
//   randnum        : free-running random source, sampled in last SPIN cycle
//   playerBalance  : current balance
//   landed         : slot of the last settled spin
//   busy           : SPIN or SETTLE
//   result_valid   : RESULT state
//   win, lose      : outcome of the last spin
//   reject         : one-cycle pulse after an illegal start
//   bust           : BUST state (absorbing until reset)
//   streak         : consecutive wins, saturating at 15
// Optional feature macro: ROULETTE_STREAK_EN (streak tracking + bonus);
// without it streak stays 0.
module roulette_engine import roulette_pkg::*; #(
   parameter int unsigned NUM_SLOTS   = 32,
   parameter int unsigned SLOT_W      = $clog2(NUM_SLOTS),
   parameter int unsigned BAL_W       = 8,
   parameter int unsigned BET_W       = 4,
   parameter int unsigned START_BAL   = 10,
   parameter int unsigned SPIN_CYCLES = 16,
   parameter int unsigned EXACT_MULT  = 2
) (
   input  logic              Clock,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [SLOT_W-1:0] playerGuess,
   input  logic [BET_W-1:0]  bet,
   input  logic [SLOT_W-1:0] randnum,
   output logic [BAL_W-1:0]  playerBalance,
   output logic [SLOT_W-1:0] landed,
   output logic              busy,
   output logic              result_valid,
   output logic              win,
   output logic              lose,
   output logic              reject,
   output logic              bust,
   output logic [3:0]        streak
);

   localparam int unsigned     CNT_W = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
   localparam logic [SLOT_W:0] NS_W  = (SLOT_W + 1)'(NUM_SLOTS);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        mode_q;
   logic [SLOT_W-1:0] guess_q;
   logic [BET_W-1:0]  bet_q;
   logic [SLOT_W-1:0] slot_q;
   logic [SLOT_W-1:0] landed_q;
   logic [BAL_W-1:0]  bal_q;
   logic              win_q;
   logic              lose_q;
   logic              reject_q;
   logic [3:0]        streak_q;

   logic              legal;
   logic              spin_last;
   logic [SLOT_W:0]   rnd_ext;
   logic [SLOT_W-1:0] slot_in;
   logic              pay_win;
   logic [BAL_W-1:0]  pay_bal;

   assign legal = (bet != '0) && (32'(bet) <= 32'(bal_q)) &&
                  !((mode == MODE_EXACT) && (32'(playerGuess) >= NUM_SLOTS));

   assign spin_last = (cnt_q == CNT_W'(SPIN_CYCLES - 1));

   // A single subtraction folds any source value into range (source < 2*NUM_SLOTS).
   assign rnd_ext = {1'b0, randnum};
   assign slot_in = (rnd_ext >= NS_W) ? SLOT_W'(rnd_ext - NS_W) : randnum;

   roulette_payout #(
      .NUM_SLOTS (NUM_SLOTS),
      .SLOT_W    (SLOT_W),
      .BAL_W     (BAL_W),
      .BET_W     (BET_W),
      .EXACT_MULT(EXACT_MULT)
   ) u_payout (
      .mode        (mode_q),
      .guess       (guess_q),
      .landed      (slot_q),
      .bet         (bet_q),
      .balance     (bal_q),
      .streak      (streak_q),
      .win         (pay_win),
      .next_balance(pay_bal)
   );

   always_ff @(posedge Clock) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         mode_q   <= MODE_EXACT;
         guess_q  <= '0;
         bet_q    <= '0;
         slot_q   <= '0;
         landed_q <= '0;
         bal_q    <= BAL_W'(START_BAL);
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
         reject_q <= 1'b0;
         streak_q <= '0;
      end else begin
         reject_q <= 1'b0;
         unique case (state_q)
            StIdle, StResult: begin
               if (start) begin
                  if (legal) begin
                     state_q <= StSpin;
                     cnt_q   <= '0;
                     mode_q  <= mode;
                     guess_q <= playerGuess;
                     bet_q   <= bet;
                  end else begin
                     reject_q <= 1'b1;
                  end
               end
            end
            StSpin: begin
               if (spin_last) begin
                  slot_q  <= slot_in;
                  state_q <= StSettle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StSettle: begin
               landed_q <= slot_q;
               bal_q    <= pay_bal;
               win_q    <= pay_win;
               lose_q   <= !pay_win;
`ifdef ROULETTE_STREAK_EN
               if (pay_win) begin
                  streak_q <= (streak_q == 4'd15) ? 4'd15 : streak_q + 4'd1;
               end else begin
                  streak_q <= 4'd0;
               end
`endif
               state_q <= (pay_bal == '0) ? StBust : StResult;
            end
            StBust:  state_q <= StBust;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign playerBalance = bal_q;
   assign landed        = landed_q;
   assign busy          = (state_q == StSpin) || (state_q == StSettle);
   assign result_valid  = (state_q == StResult);
   assign bust          = (state_q == StBust);
   assign win           = win_q;
   assign lose          = lose_q;
   assign reject        = reject_q;
   assign streak        = streak_q;

endmodule

// File: tb/tb_roulette_engine.sv
module tb_roulette_engine;

   localparam int SPIN = 16;
`ifdef ROULETTE_STREAK_EN
   localparam int STREAK_ON = 1;
`else
   localparam int STREAK_ON = 0;
`endif

   typedef struct packed {
      logic [7:0] bal;
      logic [5:0] landed;
      logic       win;
      logic       bust;
      logic [3:0] streak;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   // DUT A: default parameters
   logic       a_start = 1'b0;
   logic [1:0] a_mode = 2'b00;
   logic [4:0] a_guess = '0;
   logic [3:0] a_bet = '0;
   logic [4:0] a_rnd = '0;
   logic [7:0] a_bal;
   logic [4:0] a_landed;
   logic       a_busy, a_rv, a_win, a_lose, a_reject, a_bust;
   logic [3:0] a_streak;

   // DUT B: 37-slot wheel starting near the balance ceiling
   logic       b_start = 1'b0;
   logic [1:0] b_mode = 2'b00;
   logic [5:0] b_guess = '0;
   logic [3:0] b_bet = '0;
   logic [5:0] b_rnd = '0;
   logic [7:0] b_bal;
   logic [5:0] b_landed;
   logic       b_busy, b_rv, b_win, b_lose, b_reject, b_bust;
   logic [3:0] b_streak;

   always #5 clk = ~clk;

   roulette_engine u_dut_a (
      .Clock(clk), .reset(reset), .start(a_start), .mode(a_mode), .playerGuess(a_guess),
      .bet(a_bet), .randnum(a_rnd), .playerBalance(a_bal), .landed(a_landed), .busy(a_busy),
      .result_valid(a_rv), .win(a_win), .lose(a_lose), .reject(a_reject), .bust(a_bust),
      .streak(a_streak)
   );

   roulette_engine #(.NUM_SLOTS(37), .SLOT_W(6), .START_BAL(250)) u_dut_b (
      .Clock(clk), .reset(reset), .start(b_start), .mode(b_mode), .playerGuess(b_guess),
      .bet(b_bet), .randnum(b_rnd), .playerBalance(b_bal), .landed(b_landed), .busy(b_busy),
      .result_valid(b_rv), .win(b_win), .lose(b_lose), .reject(b_reject), .bust(b_bust),
      .streak(b_streak)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input int bal, input int landed, input bit w, input bit b,
                               input int s);
      exp_t e;
      e.bal    = 8'(bal);
      e.landed = 6'(landed);
      e.win    = w;
      e.bust   = b;
      e.streak = 4'(s);
      return e;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // One spin on DUT A: push the expectation, drive a one-cycle start, wait for the outcome.
   task automatic do_spin(input string tag, input logic [1:0] m, input logic [4:0] g,
                          input logic [3:0] b, input logic [4:0] r, input exp_t e);
      int   n;
      exp_t x;
      exp_q.push_back(e);
      a_mode  = m;
      a_guess = g;
      a_bet   = b;
      a_rnd   = r;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      chk({tag, "_busy"}, 32'(a_busy), 32'd1);
      n = 0;
      while (!(a_rv || a_bust) && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, n, SPIN + 1);
      x = exp_q.pop_front();
      chk({tag, "_bal"}, 32'(a_bal), 32'(x.bal));
      chk({tag, "_landed"}, 32'(a_landed), 32'(x.landed));
      chk({tag, "_win"}, 32'(a_win), 32'(x.win));
      chk({tag, "_lose"}, 32'(a_lose), 32'(!x.win));
      chk({tag, "_bust"}, 32'(a_bust), 32'(x.bust));
      chk({tag, "_rv"}, 32'(a_rv), 32'(!x.bust));
      chk({tag, "_streak"}, 32'(a_streak), 32'(x.streak));
   endtask

   initial begin
      int   n;
      int   rv_seen;
      exp_t x;

      // Reset with a legal start held high: reset must win.
      a_start = 1'b1;
      a_mode  = 2'b00;
      a_guess = 5'd7;
      a_bet   = 4'd1;
      step();
      step();
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_bal", 32'(a_bal), 32'd10);
      chk("rst_landed", 32'(a_landed), 32'd0);
      chk("rst_streak", 32'(a_streak), 32'd0);
      chk("rst_flags", {a_rv, a_win, a_lose, a_reject, a_bust}, 32'd0);
      a_start = 1'b0;
      reset   = 1'b0;

      // EXACT guess 7, bet 1, wheel lands on 7 -> +2
      do_spin("exact_win", 2'b00, 5'd7, 4'd1, 5'd7, mk(12, 7, 1, 0, STREAK_ON));

      // EVEN loses on slot 0; ODD back-to-back from the first RESULT cycle
      do_reset();
      do_spin("even_zero", 2'b01, 5'd0, 4'd3, 5'd0, mk(7, 0, 0, 0, 0));
      do_spin("odd_win", 2'b10, 5'd0, 4'd2, 5'd5, mk(9, 5, 1, 0, STREAK_ON));

      // Illegal starts: bet above balance, then zero bet
      do_reset();
      a_mode  = 2'b10;
      a_bet   = 4'd11;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      chk("rej_big_pulse", 32'(a_reject), 32'd1);
      chk("rej_big_busy", 32'(a_busy), 32'd0);
      step();
      chk("rej_big_once", 32'(a_reject), 32'd0);
      chk("rej_big_bal", 32'(a_bal), 32'd10);
      a_bet   = 4'd0;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      chk("rej_zero_pulse", 32'(a_reject), 32'd1);
      step();
      chk("rej_zero_once", 32'(a_reject), 32'd0);
      chk("rej_zero_idle", {a_busy, a_rv, a_bust}, 32'd0);
      chk("rej_zero_bal", 32'(a_bal), 32'd10);

      // Lose the whole balance -> BUST, which ignores further starts
      do_spin("bust", 2'b10, 5'd0, 4'd10, 5'd4, mk(0, 4, 0, 1, 0));
      a_bet   = 4'd1;
      a_start = 1'b1;
      step();
      step();
      a_start = 1'b0;
      chk("bust_hold", 32'(a_bust), 32'd1);
      chk("bust_noreject", 32'(a_reject), 32'd0);
      chk("bust_nobusy", 32'(a_busy), 32'd0);
      do_reset();
      chk("bust_reset_bust", 32'(a_bust), 32'd0);
      chk("bust_reset_bal", 32'(a_bal), 32'd10);

      // Reset in SPIN cycle 5 discards the spin
      a_mode  = 2'b11;
      a_bet   = 4'd1;
      a_rnd   = 5'd20;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("midspin_busy", 32'(a_busy), 32'd1);
      do_reset();
      chk("midspin_idle", 32'(a_busy), 32'd0);
      chk("midspin_bal", 32'(a_bal), 32'd10);
      rv_seen = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (a_rv) rv_seen++;
      end
      chk("midspin_norv", rv_seen, 0);

      // Three HIGH wins at bet 1; third win earns the streak bonus when enabled
      do_spin("high1", 2'b11, 5'd0, 4'd1, 5'd20, mk(11, 20, 1, 0, STREAK_ON));
      do_spin("high2", 2'b11, 5'd0, 4'd1, 5'd17, mk(12, 17, 1, 0, 2 * STREAK_ON));
      do_spin("high3", 2'b11, 5'd0, 4'd1, 5'd31, mk(13 + STREAK_ON, 31, 1, 0, 3 * STREAK_ON));

      // DUT B: randnum 40 folds to slot 3; EXACT win of 10 from 250 saturates at 255
      do_reset();
      chk("b_rst_bal", 32'(b_bal), 32'd250);
      exp_q.push_back(mk(255, 3, 1, 0, STREAK_ON));
      b_mode  = 2'b00;
      b_guess = 6'd3;
      b_bet   = 4'd5;
      b_rnd   = 6'd40;
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      n = 0;
      while (!(b_rv || b_bust) && n < 40) begin
         step();
         n++;
      end
      x = exp_q.pop_front();
      chk("b_latency", n, SPIN + 1);
      chk("b_landed", 32'(b_landed), 32'(x.landed));
      chk("b_bal_sat", 32'(b_bal), 32'(x.bal));
      chk("b_win", 32'(b_win), 32'(x.win));
      chk("b_streak", 32'(b_streak), 32'(x.streak));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
